// File: rtl/cr_tlvp2_split_core_pkg.sv
// cr_tlvp2_split_core_pkg: bus/header types, widths and BIP2 helper for the TLVP2 ingress splitter.
package cr_tlvp2_split_core_pkg;
  localparam int LEN_W = 24;
  localparam int TLVP_ORD_NUM_WIDTH = 4;
  localparam int TLVP_TYP_NUM_WIDTH = 5;

  typedef struct packed {
    logic        tlast;
    logic [1:0]  tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic [1:0]       bip2;
    logic [29:0]      rsvd;
    logic [LEN_W-1:0] tlv_len;
    logic [7:0]       tlv_type;
  } tlv_word_0_t;

  typedef struct packed {
    logic                          insert;
    logic [TLVP_ORD_NUM_WIDTH-1:0] ordern;
    logic [TLVP_TYP_NUM_WIDTH-1:0] typen;
    logic                          sot;
    logic                          eot;
    logic                          tlast;
    logic [1:0]                    tid;
    logic [7:0]                    tstrb;
    logic [7:0]                    tuser;
    logic [63:0]                   tdata;
  } tlvp_if_bus_t;

  typedef enum logic {HDR, BODY} state_e;

  function automatic logic [1:0] get_bip2(input logic [63:0] d);
    logic [1:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) b = b ^ d[2*i +: 2];
    return b;
  endfunction
endpackage

// File: rtl/cr_tlvp2_split_hdr_dec.sv
// cr_tlvp2_split_hdr_dec: combinational TLV header decode (type, 64-bit word count, zero length).
// Header BIP2 check is compiled in only with CR_TLVP2_SPLIT_BIP2_CHK_EN.
module cr_tlvp2_split_hdr_dec
  import cr_tlvp2_split_core_pkg::*;
(
  input  logic [63:0]                   tdata,
  output logic [TLVP_TYP_NUM_WIDTH-1:0] typen,
  output logic [LEN_W-1:0]              words,
  output logic                          zlen,
  output logic                          bip2_bad
);
  tlv_word_0_t    hdr;
  logic [LEN_W:0] len_p1;
  logic           unused;
  assign hdr    = tlv_word_0_t'(tdata);
  assign typen  = hdr.tlv_type[TLVP_TYP_NUM_WIDTH-1:0];
  assign zlen   = hdr.tlv_len == '0;
  // two dwords per data word, rounded up; a zero length still occupies its header word
  assign len_p1 = {1'b0, hdr.tlv_len} + (LEN_W+1)'(1);
  assign words  = zlen ? LEN_W'(1) : len_p1[LEN_W:1];
`ifdef CR_TLVP2_SPLIT_BIP2_CHK_EN
  assign bip2_bad = hdr.bip2 != get_bip2({2'b00, tdata[61:0]});
`else
  assign bip2_bad = 1'b0;
`endif
  assign unused = ^{hdr.rsvd, hdr.bip2, hdr.tlv_type, len_p1[0]};
endmodule

// File: rtl/cr_tlvp2_split_core.sv
// cr_tlvp2_split_core: parses the ingress stream into TLVs, tags each word and routes whole TLVs
// to the user or pass-through FIFO. Optional header BIP2 check: CR_TLVP2_SPLIT_BIP2_CHK_EN.
module cr_tlvp2_split_core
  import cr_tlvp2_split_core_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ib_tvalid,
  input  axi4s_dp_bus_t                       ib_tdata,
  output logic                                ib_tready,
  input  logic [2**TLVP_TYP_NUM_WIDTH-1:0]    usr_type_en,
  input  logic                                usr_ib_full,
  input  logic                                usr_ib_afull,
  output logic                                usr_ib_wen,
  output tlvp_if_bus_t                        usr_ib_wdata,
  input  logic                                pt_ib_full,
  input  logic                                pt_ib_afull,
  output logic                                pt_ib_wr,
  output tlvp_if_bus_t                        pt_ib_tlv,
  output logic                                len_err,
  output logic                                bip2_err
);
  localparam int OW = TLVP_ORD_NUM_WIDTH;
  localparam int TW = TLVP_TYP_NUM_WIDTH;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, dec_words, rem;
  logic [TW-1:0]    typ_q, typ_d, dec_typ;
  logic [OW-1:0]    ord_q, ord_d, tord_q, tord_d;
  logic             dst_q, dst_d, rdy_q;
  logic             wen_q, wen_d, wr_q, wr_d, lerr_q, lerr_d, berr_q, berr_d;
  logic             dec_zlen, dec_bip2_bad, acc, is_hdr, eot;
  tlvp_if_bus_t     out_q, out_d;

  cr_tlvp2_split_hdr_dec u_hdr_dec (
    .tdata    (ib_tdata.tdata),
    .typen    (dec_typ),
    .words    (dec_words),
    .zlen     (dec_zlen),
    .bip2_bad (dec_bip2_bad)
  );

  assign ib_tready = rdy_q & ~usr_ib_afull & ~pt_ib_afull;

  // ord_q always holds the ordern the next TLV header will take
  always_comb begin
    acc     = ib_tvalid & ib_tready;
    is_hdr  = (state_q == HDR) | ib_tdata.tuser[0];
    rem     = is_hdr ? dec_words : cnt_q;
    eot     = ib_tdata.tlast | (rem == LEN_W'(1));
    state_d = state_q;
    cnt_d   = cnt_q;
    typ_d   = typ_q;
    dst_d   = dst_q;
    ord_d   = ord_q;
    tord_d  = tord_q;
    out_d   = out_q;
    wen_d   = 1'b0;
    wr_d    = 1'b0;
    lerr_d  = 1'b0;
    berr_d  = 1'b0;
    if (acc) begin
      if (is_hdr) begin
        typ_d  = dec_typ;
        dst_d  = usr_type_en[dec_typ];
        tord_d = ord_q;
        ord_d  = ord_q + OW'(1);
      end
      if (ib_tdata.tlast) ord_d = OW'(1);
      state_d      = eot ? HDR : BODY;
      cnt_d        = rem - LEN_W'(1);
      wen_d        = dst_d;
      wr_d         = ~dst_d;
      // a header arriving in BODY is a resync that truncates the open TLV
      lerr_d       = (is_hdr & (dec_zlen | (state_q == BODY))) | (ib_tdata.tlast & (rem > LEN_W'(1)));
      berr_d       = is_hdr & dec_bip2_bad;
      out_d.insert = 1'b0;
      out_d.ordern = tord_d;
      out_d.typen  = typ_d;
      out_d.sot    = is_hdr;
      out_d.eot    = eot;
      out_d.tlast  = ib_tdata.tlast;
      out_d.tid    = ib_tdata.tid;
      out_d.tstrb  = ib_tdata.tstrb;
      out_d.tuser  = ib_tdata.tuser;
      out_d.tdata  = ib_tdata.tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR;
      cnt_q   <= '0;
      typ_q   <= '0;
      dst_q   <= 1'b0;
      ord_q   <= OW'(1);
      tord_q  <= '0;
      out_q   <= '0;
      wen_q   <= 1'b0;
      wr_q    <= 1'b0;
      lerr_q  <= 1'b0;
      berr_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      typ_q   <= typ_d;
      dst_q   <= dst_d;
      ord_q   <= ord_d;
      tord_q  <= tord_d;
      out_q   <= out_d;
      wen_q   <= wen_d;
      wr_q    <= wr_d;
      lerr_q  <= lerr_d;
      berr_q  <= berr_d;
      rdy_q   <= 1'b1;
    end
  end

  assign usr_ib_wen   = wen_q;
  assign pt_ib_wr     = wr_q;
  assign usr_ib_wdata = out_q;
  assign pt_ib_tlv    = out_q;
  assign len_err      = lerr_q;
  assign bip2_err     = berr_q;

  a_usr_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(usr_ib_wen && usr_ib_full));
  a_pt_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(pt_ib_wr && pt_ib_full));
endmodule

// File: tb/tb_cr_tlvp2_split_core.sv
// tb_cr_tlvp2_split_core: directed and random frames checked against a frame-level expectation queue.
module tb_cr_tlvp2_split_core;
  import cr_tlvp2_split_core_pkg::*;
  localparam int OW = TLVP_ORD_NUM_WIDTH;
  localparam int TW = TLVP_TYP_NUM_WIDTH;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   ib_tvalid = 1'b0;
  axi4s_dp_bus_t          ib_tdata = '0;
  logic                   ib_tready;
  logic [2**TW-1:0]       usr_type_en = '0;
  logic                   usr_ib_full = 1'b0, usr_ib_afull = 1'b0, usr_ib_wen;
  logic                   pt_ib_full = 1'b0, pt_ib_afull = 1'b0, pt_ib_wr;
  logic                   len_err, bip2_err;
  tlvp_if_bus_t           usr_ib_wdata, pt_ib_tlv;

  cr_tlvp2_split_core dut (
    .clk(clk), .rst_n(rst_n), .ib_tvalid(ib_tvalid), .ib_tdata(ib_tdata), .ib_tready(ib_tready),
    .usr_type_en(usr_type_en), .usr_ib_full(usr_ib_full), .usr_ib_afull(usr_ib_afull),
    .usr_ib_wen(usr_ib_wen), .usr_ib_wdata(usr_ib_wdata), .pt_ib_full(pt_ib_full),
    .pt_ib_afull(pt_ib_afull), .pt_ib_wr(pt_ib_wr), .pt_ib_tlv(pt_ib_tlv),
    .len_err(len_err), .bip2_err(bip2_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    tlvp_if_bus_t bus;
    logic         usr;
    logic         lerr;
    logic         berr;
  } exp_t;

  exp_t q[$];
  int   n_run = 0, n_fail = 0;
  int   f_n;
  int   f_typ[20], f_len[20], f_sent[20];
  bit   f_bad[20];
  int   bp_at = -1;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_bip2(input logic [63:0] d);
    logic [1:0] b;
    b = '0;
    for (int i = 0; i < 64; i++) b[i%2] = b[i%2] ^ d[i];
    return b;
  endfunction

  task automatic set_tlv(input int k, input int typ, input int len, input int sent, input bit bad);
    f_typ[k] = typ; f_len[k] = len; f_sent[k] = sent; f_bad[k] = bad;
  endtask

  task automatic rnd_afull();
    usr_ib_afull = ($urandom_range(0, 9) == 0);
    pt_ib_afull  = ($urandom_range(0, 9) == 0);
  endtask

  task automatic put_word(input axi4s_dp_bus_t w);
    int guard;
    guard = 0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk); ib_tvalid = 1'b0; rnd_afull();
    end
    @(negedge clk); ib_tvalid = 1'b1; ib_tdata = w; rnd_afull();
    forever begin
      #1;
      if (ib_tready) break;
      if (++guard > 1000) begin chk("accept_timeout", 1, 0); break; end
      @(negedge clk); rnd_afull();
    end
    @(posedge clk);
  endtask

  task automatic hold_word(input axi4s_dp_bus_t w);
    @(negedge clk); ib_tvalid = 1'b1; ib_tdata = w; usr_ib_afull = 1'b1; pt_ib_afull = 1'b0;
    repeat (7) begin
      #1 chk("bp_ready_low", ib_tready, 0);
      @(negedge clk);
    end
    usr_ib_afull = 1'b0;
    #1 chk("bp_ready_high", ib_tready, 1);
    @(posedge clk);
  endtask

  // frame-level model: each TLV's tags follow from its declared length and how many words were sent
  task automatic send_frame(input bit end_tlast);
    bit prev_trunc;
    int wi;
    prev_trunc = 0;
    wi = 0;
    for (int k = 0; k < f_n; k++) begin
      int decl;
      decl = (f_len[k] == 0) ? 1 : (f_len[k] + 1) / 2;
      for (int j = 0; j < f_sent[k]; j++) begin
        axi4s_dp_bus_t w;
        exp_t e;
        w.tid   = 2'($urandom);
        w.tstrb = 8'($urandom);
        w.tuser = 8'($urandom);
        w.tdata = {$urandom, $urandom};
        w.tlast = end_tlast && k == f_n - 1 && j == f_sent[k] - 1;
        if (j == 0) begin
          w.tdata[31:0]  = {24'(f_len[k]), 3'($urandom), 5'(f_typ[k])};
          w.tdata[63:62] = ref_bip2({2'b00, w.tdata[61:0]}) ^ {1'b0, f_bad[k]};
          if (prev_trunc) w.tuser[0] = 1'b1;
        end else w.tuser[0] = 1'b0;
        e.bus        = '0;
        e.bus.ordern = OW'(k + 1);
        e.bus.typen  = TW'(f_typ[k]);
        e.bus.sot    = (j == 0);
        e.bus.eot    = (j == f_sent[k] - 1) && (f_sent[k] == decl || w.tlast);
        e.bus.tlast  = w.tlast;
        e.bus.tid    = w.tid;
        e.bus.tstrb  = w.tstrb;
        e.bus.tuser  = w.tuser;
        e.bus.tdata  = w.tdata;
        e.usr        = usr_type_en[f_typ[k]];
        e.lerr       = (j == 0 && (f_len[k] == 0 || prev_trunc)) || (w.tlast && f_sent[k] < decl);
`ifdef CR_TLVP2_SPLIT_BIP2_CHK_EN
        e.berr       = (j == 0) && f_bad[k];
`else
        e.berr       = 1'b0;
`endif
        q.push_back(e);
        if (wi == bp_at) hold_word(w); else put_word(w);
        wi++;
      end
      prev_trunc = f_sent[k] < decl;
    end
    @(negedge clk); ib_tvalid = 1'b0; usr_ib_afull = 1'b0; pt_ib_afull = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (usr_ib_wen || pt_ib_wr) begin
        if (q.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("port", {usr_ib_wen, pt_ib_wr}, e.usr ? 2'b10 : 2'b01);
          chk("word", e.usr ? usr_ib_wdata : pt_ib_tlv, e.bus);
          chk("len_err", len_err, e.lerr);
          chk("bip2_err", bip2_err, e.berr);
        end
      end else chk("idle_err", {len_err, bip2_err}, 0);
    end
  end

  task automatic chk_reset_state();
    chk("rst_tready", ib_tready, 0);
    chk("rst_wen", {usr_ib_wen, pt_ib_wr}, 0);
    chk("rst_usr_data", usr_ib_wdata, 0);
    chk("rst_pt_data", pt_ib_tlv, 0);
    chk("rst_err", {len_err, bip2_err}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_state();
    rst_n = 1'b1;
    // ordern 1 and 2, then the next frame restarts at 1; type 5 to user, type 1 to pass-through
    usr_type_en = 32'h0000_0020;
    f_n = 2; set_tlv(0, 5, 2, 1, 0); set_tlv(1, 1, 5, 3, 0); send_frame(1);
    f_n = 1; set_tlv(0, 5, 2, 1, 0); send_frame(1);
    // seven-cycle user backpressure on the second word of a five-word TLV
    f_n = 1; set_tlv(0, 5, 9, 5, 0); bp_at = 1; send_frame(1); bp_at = -1;
    // early tlast, then zero length and a resync inside BODY
    f_n = 1; set_tlv(0, 1, 8, 2, 0); send_frame(1);
    f_n = 3; set_tlv(0, 3, 0, 1, 0); set_tlv(1, 2, 7, 2, 0); set_tlv(2, 4, 4, 2, 0); send_frame(1);
    // corrupted header BIP2
    f_n = 2; set_tlv(0, 5, 3, 2, 1); set_tlv(1, 1, 2, 1, 0); send_frame(1);
    // ordern wraps past 2**OW-1
    f_n = 18;
    for (int k = 0; k < 18; k++) set_tlv(k, $urandom_range(0, 31), $urandom_range(1, 2), 1, 0);
    usr_type_en = $urandom;
    send_frame(1);
    // reset in the middle of a TLV discards it; the next word is a header with ordern 1
    f_n = 1; set_tlv(0, 6, 10, 2, 0); send_frame(0);
    repeat (3) @(negedge clk);
    chk("pre_reset_drained", q.size(), 0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state();
    rst_n = 1'b1;
    f_n = 1; set_tlv(0, 7, 3, 2, 0); send_frame(1);
    for (int fr = 0; fr < 40; fr++) begin
      usr_type_en = $urandom;
      f_n = $urandom_range(1, 4);
      for (int k = 0; k < f_n; k++) begin
        int r, len, decl, sent;
        r = $urandom_range(0, 9);
        len = (r == 0) ? 0 : (r == 1) ? 24'hFFFFFF : $urandom_range(1, 10);
        decl = (len == 0) ? 1 : (len + 1) / 2;
        sent = (decl > 6) ? $urandom_range(1, 4) :
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, decl) : decl;
        set_tlv(k, $urandom_range(0, 31), len, sent, $urandom_range(0, 7) == 0);
      end
      send_frame(1);
    end
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
